// File: rtl/mil_bus_pkg.sv
// Shared word, fill-level and handshake-state types for the MIL bus datapath.
// The FSM enums are reused by every request/done handshake stage.
package mil_bus_pkg;

  typedef logic [15:0] word_t;

  localparam int FIFO_DEPTH_DEF = 16;

  typedef logic [$clog2(FIFO_DEPTH_DEF):0] fill_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_PEND = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_PEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port word store: synchronous write, registered synchronous read.
// No reset on the array or read register, so a vendor RAM primitive can drop in.
module fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/word_fifo.sv
// Word ring buffer between the SPI/MIL receivers and the bus pusher.
// Pulse request/done handshakes; a request that hits full/empty waits in a pending state.
module word_fifo
  import mil_bus_pkg::*;
#(
  parameter int DATA_W = $bits(word_t),
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_request,
  output logic              push_done,
  input  logic              pop_request,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("word_fifo: DEPTH must be a power of two and at least 2");
  end

  wr_state_e         w_state_reg, w_state_next;
  rd_state_e         r_state_reg, r_state_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] hold_reg;
  logic              push_done_reg, pop_done_reg;
  logic              data_valid_reg;
  logic              wr_fire, wr_sel_hold, hold_load, rd_fire;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign push_done = push_done_reg;
  assign pop_done  = pop_done_reg;
  // The RAM read register has no reset; report zero until the first real pop.
  assign pop_data  = data_valid_reg ? ram_rd_data : '0;

  always_comb begin
    w_state_next = w_state_reg;
    wr_fire      = 1'b0;
    wr_sel_hold  = 1'b0;
    hold_load    = 1'b0;
    if (flush) begin
      w_state_next = W_IDLE;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (push_request && !push_done_reg) begin
            if (!full) begin
              wr_fire = 1'b1;
            end else begin
              hold_load    = 1'b1;
              w_state_next = W_PEND;
            end
          end
        end
        W_PEND: begin
          if (!full) begin
            wr_fire      = 1'b1;
            wr_sel_hold  = 1'b1;
            w_state_next = W_IDLE;
          end
        end
        default: w_state_next = W_IDLE;
      endcase
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    rd_fire      = 1'b0;
    if (flush) begin
      r_state_next = R_IDLE;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (pop_request && !pop_done_reg) begin
            if (!empty) begin
              rd_fire = 1'b1;
            end else begin
              r_state_next = R_PEND;
            end
          end
        end
        R_PEND: begin
          if (!empty) begin
            rd_fire      = 1'b1;
            r_state_next = R_IDLE;
          end
        end
        default: r_state_next = R_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_fire) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (rd_fire) rd_ptr_next = rd_ptr_reg + AW'(1);
      if (wr_fire && !rd_fire) begin
        count_next = count_reg + CNT_W'(1);
      end else if (rd_fire && !wr_fire) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg    <= W_IDLE;
      r_state_reg    <= R_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      hold_reg       <= '0;
      push_done_reg  <= 1'b0;
      pop_done_reg   <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      w_state_reg   <= w_state_next;
      r_state_reg   <= r_state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      push_done_reg <= wr_fire;
      pop_done_reg  <= rd_fire;
      if (hold_load) hold_reg <= push_data;
      if (rd_fire) data_valid_reg <= 1'b1;
    end
  end

  assign ram_wr_data = wr_sel_hold ? hold_reg : push_data;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire && !rst),
    .wr_addr (wr_ptr_reg),
    .wr_data (ram_wr_data),
    .rd_en   (rd_fire && !rst),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  // A second request while the side is pending or signalling done is dropped.
  a_push_protocol : assert property (@(posedge clk) disable iff (rst || flush)
    push_request |-> (w_state_reg == W_IDLE && !push_done_reg))
    else $error("word_fifo: push_request while write side busy");

  a_pop_protocol : assert property (@(posedge clk) disable iff (rst || flush)
    pop_request |-> (r_state_reg == R_IDLE && !pop_done_reg))
    else $error("word_fifo: pop_request while read side busy");

endmodule

// File: tb/tb_word_fifo.sv
// Directed self-checking bench for word_fifo: handshakes, wrap, full/empty stalls,
// flush and reset while a request is pending.
module tb_word_fifo;
  import mil_bus_pkg::*;

  logic  clk = 1'b0;
  logic  rst, flush;
  word_t push_data, pop_data;
  logic  push_request, push_done, pop_request, pop_done;
  fill_t count;
  logic  empty, full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_fifo #(
    .DATA_W (16),
    .DEPTH  (16),
    .CNT_W  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_data    (push_data),
    .push_request (push_request),
    .push_done    (push_done),
    .pop_request  (pop_request),
    .pop_data     (pop_data),
    .pop_done     (pop_done),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input word_t d);
    push_request = 1'b1;
    push_data    = d;
    cyc();
    push_request = 1'b0;
    $display("push data=%h done=%b count=%0d", d, push_done, count);
    cyc();
  endtask

  task automatic pop_word(output word_t d, output logic done);
    pop_request = 1'b1;
    cyc();
    pop_request = 1'b0;
    d    = pop_data;
    done = pop_done;
    $display("pop  data=%h done=%b count=%0d", d, done, count);
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; push_request = 1'b0; pop_request = 1'b0; push_data = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
    total++; if (push_done !== 1'b0 || pop_done !== 1'b0) begin bad++; $display("FAIL reset_done got push=%b pop=%b want 0 0", push_done, pop_done); end
    total++; if (pop_data !== 16'h0000) begin bad++; $display("FAIL reset_pop_data got=%h want=0000", pop_data); end
  endtask

  task automatic test_single();
    push_request = 1'b1; push_data = 16'hA5A5;
    cyc();
    push_request = 1'b0;
    total++; if (push_done !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL single_push got done=%b count=%0d want 1 1", push_done, count); end
    cyc();
    cyc();
    pop_request = 1'b1;
    cyc();
    pop_request = 1'b0;
    total++; if (pop_done !== 1'b1 || pop_data !== 16'hA5A5) begin bad++; $display("FAIL single_pop got done=%b data=%h want 1 a5a5", pop_done, pop_data); end
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL single_empty got count=%0d empty=%b want 0 1", count, empty); end
    cyc();
  endtask

  task automatic test_fill_wrap();
    word_t d;
    logic  dn;
    for (int i = 1; i <= 16; i++) begin
      push_request = 1'b1; push_data = word_t'(i);
      cyc();
      push_request = 1'b0;
      total++; if (push_done !== 1'b1) begin bad++; $display("FAIL fill_push_done word=%0d got=%b want=1", i, push_done); end
      cyc();
    end
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fill_full got count=%0d full=%b want 16 1", count, full); end
    for (int i = 1; i <= 4; i++) begin
      pop_word(d, dn);
      total++; if (dn !== 1'b1 || d !== word_t'(i)) begin bad++; $display("FAIL wrap_pop got done=%b data=%h want 1 %h", dn, d, word_t'(i)); end
    end
    for (int i = 17; i <= 20; i++) push_word(word_t'(i));
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL wrap_refill got count=%0d full=%b want 16 1", count, full); end
    for (int i = 5; i <= 20; i++) begin
      pop_word(d, dn);
      total++; if (dn !== 1'b1 || d !== word_t'(i)) begin bad++; $display("FAIL wrap_drain got done=%b data=%h want 1 %h", dn, d, word_t'(i)); end
    end
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL wrap_empty got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_push_full();
    word_t d;
    logic  dn;
    for (int i = 0; i < 16; i++) push_word(16'h0100 + word_t'(i));
    push_request = 1'b1; push_data = 16'hBEEF;
    cyc();
    push_request = 1'b0;
    total++; if (push_done !== 1'b0) begin bad++; $display("FAIL full_push_held got done=%b want=0", push_done); end
    cyc();
    cyc();
    total++; if (push_done !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL full_push_wait got done=%b count=%0d want 0 16", push_done, count); end
    pop_request = 1'b1;
    cyc();
    pop_request = 1'b0;
    total++; if (pop_done !== 1'b1 || pop_data !== 16'h0100 || push_done !== 1'b0) begin bad++; $display("FAIL full_pop_n1 got pop=%b data=%h push=%b want 1 0100 0", pop_done, pop_data, push_done); end
    cyc();
    total++; if (push_done !== 1'b1 || pop_done !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL full_push_n2 got push=%b pop=%b count=%0d want 1 0 16", push_done, pop_done, count); end
    cyc();
    for (int i = 1; i < 16; i++) begin
      pop_word(d, dn);
      total++; if (dn !== 1'b1 || d !== 16'h0100 + word_t'(i)) begin bad++; $display("FAIL full_drain got done=%b data=%h want 1 %h", dn, d, 16'h0100 + word_t'(i)); end
    end
    pop_word(d, dn);
    total++; if (dn !== 1'b1 || d !== 16'hBEEF) begin bad++; $display("FAIL full_last_beef got done=%b data=%h want 1 beef", dn, d); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_pop_empty();
    logic seen = 1'b0;
    pop_request = 1'b1;
    cyc();
    pop_request = 1'b0;
    repeat (5) begin
      if (pop_done) seen = 1'b1;
      cyc();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL empty_pop_wait got pop_done seen=%b want=0", seen); end
    push_request = 1'b1; push_data = 16'h1234;
    cyc();
    push_request = 1'b0;
    total++; if (push_done !== 1'b1 || pop_done !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL empty_push_n1 got push=%b pop=%b count=%0d want 1 0 1", push_done, pop_done, count); end
    cyc();
    total++; if (pop_done !== 1'b1 || pop_data !== 16'h1234 || count !== 5'd0) begin bad++; $display("FAIL empty_pop_n2 got pop=%b data=%h count=%0d want 1 1234 0", pop_done, pop_data, count); end
    cyc();
  endtask

  task automatic test_simultaneous();
    word_t d;
    logic  dn;
    push_word(16'hC001);
    push_word(16'hC002);
    push_word(16'hC003);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL simul_pre_count got=%0d want=3", count); end
    push_request = 1'b1; push_data = 16'hC004; pop_request = 1'b1;
    cyc();
    push_request = 1'b0; pop_request = 1'b0;
    total++; if (push_done !== 1'b1 || pop_done !== 1'b1 || pop_data !== 16'hC001) begin bad++; $display("FAIL simul_dones got push=%b pop=%b data=%h want 1 1 c001", push_done, pop_done, pop_data); end
    total++; if (count !== 5'd3) begin bad++; $display("FAIL simul_count got=%0d want=3", count); end
    cyc();
    for (int i = 2; i <= 4; i++) begin
      pop_word(d, dn);
      total++; if (dn !== 1'b1 || d !== 16'hC000 + word_t'(i)) begin bad++; $display("FAIL simul_order got done=%b data=%h want 1 %h", dn, d, 16'hC000 + word_t'(i)); end
    end
  endtask

  task automatic test_flush();
    word_t d;
    logic  dn;
    logic  seen = 1'b0;
    for (int i = 0; i < 16; i++) push_word(16'hF000 + word_t'(i));
    push_request = 1'b1; push_data = 16'hAAAA;
    cyc();
    push_request = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL flush_state got count=%0d empty=%b full=%b want 0 1 0", count, empty, full); end
    total++; if (pop_data !== 16'hC004) begin bad++; $display("FAIL flush_pop_data_kept got=%h want=c004", pop_data); end
    repeat (4) begin
      if (push_done) seen = 1'b1;
      cyc();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_done got push_done seen=%b want=0", seen); end
    push_word(16'h00FF);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL flush_repush_count got=%0d want=1", count); end
    pop_word(d, dn);
    total++; if (dn !== 1'b1 || d !== 16'h00FF || empty !== 1'b1) begin bad++; $display("FAIL flush_roundtrip got done=%b data=%h empty=%b want 1 00ff 1", dn, d, empty); end
  endtask

  task automatic test_rst_mid();
    word_t d;
    logic  dn;
    logic  seen = 1'b0;
    for (int i = 0; i < 16; i++) push_word(16'hE000 + word_t'(i));
    push_request = 1'b1; push_data = 16'h5555;
    cyc();
    push_request = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_mid_state got count=%0d empty=%b full=%b want 0 1 0", count, empty, full); end
    total++; if (pop_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_pop_data got=%h want=0000", pop_data); end
    repeat (4) begin
      if (push_done) seen = 1'b1;
      cyc();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_done got push_done seen=%b want=0", seen); end
    push_word(16'h00FF);
    pop_word(d, dn);
    total++; if (dn !== 1'b1 || d !== 16'h00FF || empty !== 1'b1) begin bad++; $display("FAIL rst_mid_roundtrip got done=%b data=%h empty=%b want 1 00ff 1", dn, d, empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_push_full();
    test_pop_empty();
    test_simultaneous();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
